// File: rtl/cluster_periph_initiator_if.sv
`default_nettype none
// ============================================================================
// Module   : XBAR_PERIPH_BUS
// Brief    : Cluster peripheral interconnect request/response bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface XBAR_PERIPH_BUS #(
  parameter int unsigned ID_WIDTH = 5
);
  logic                req;
  logic [31:0]         add;
  logic                wen;
  logic [31:0]         wdata;
  logic [3:0]          be;
  logic                gnt;
  logic [ID_WIDTH-1:0] id;
  logic                r_valid;
  logic                r_opc;
  logic [ID_WIDTH-1:0] r_id;
  logic [31:0]         r_rdata;

  modport Master (
    output req, add, wen, wdata, be, id,
    input  gnt, r_valid, r_opc, r_id, r_rdata
  );

  modport Slave (
    input  req, add, wen, wdata, be, id,
    output gnt, r_valid, r_opc, r_id, r_rdata
  );
endinterface
`default_nettype wire

// File: rtl/cluster_periph_initiator.sv
`default_nettype none
// ============================================================================
// Module   : cluster_periph_initiator
// Brief    : Single-outstanding command-to-XBAR_PERIPH_BUS initiator with
//            ID tagging, timeout abort and error counting.
// Revision : 1.0 - initial release
// ============================================================================
module cluster_periph_initiator #(
  parameter int unsigned PER_ID_WIDTH   = 5,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hBADACCE5
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           cmd_valid_i,
  output logic           cmd_ready_o,
  input  logic [31:0]    cmd_addr_i,
  input  logic           cmd_we_i,
  input  logic [31:0]    cmd_wdata_i,
  input  logic [3:0]     cmd_be_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [31:0]    rsp_rdata_o,
  output logic           rsp_err_o,
  output logic           rsp_timeout_o,
  output logic [7:0]     err_cnt_o,
  XBAR_PERIPH_BUS.Master speriph_master
);

  localparam int unsigned c_timer_w =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_timer_w-1:0] c_timeout = c_timer_w'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RSP    = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic                    r_req;
  logic [31:0]             r_add;
  logic                    r_wen;
  logic [31:0]             r_wdata;
  logic [3:0]              r_be;
  logic [PER_ID_WIDTH-1:0] r_id_q;
  logic [c_timer_w-1:0]    r_timer;
  logic                    r_rsp_valid;
  logic [31:0]             r_rsp_rdata;
  logic                    r_rsp_err;
  logic                    r_rsp_timeout;
  logic [7:0]              r_err_cnt;

  logic [c_timer_w-1:0]    w_timer;
  logic                    w_timeout;
  logic                    w_match;
  logic                    w_accept;
  logic                    w_grant;
  logic                    w_capture;
  logic                    w_abort;
  logic                    w_release;

  // w_timer is the count for the current cycle: 1 in the first REQ cycle.
  always_comb begin
    w_timer      = r_timer + c_timer_w'(1);
    w_timeout    = (TIMEOUT_CYCLES != 0) && (w_timer == c_timeout);
    w_match      = speriph_master.r_valid && (speriph_master.r_id == r_id_q);
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_grant      = 1'b0;
    w_capture    = 1'b0;
    w_abort      = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid_i) begin
          w_accept     = 1'b1;
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (speriph_master.gnt) begin
          w_grant      = 1'b1;
          w_state_next = WAIT_R;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_state_next = RSP;
        end
      end
      WAIT_R: begin
        if (w_match) begin
          w_capture    = 1'b1;
          w_state_next = RSP;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_state_next = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          w_release    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req         <= 1'b0;
      r_add         <= '0;
      r_wen         <= 1'b0;
      r_wdata       <= '0;
      r_be          <= '0;
      r_id_q        <= '0;
      r_timer       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_req   <= 1'b1;
        r_add   <= cmd_addr_i;
        r_wen   <= ~cmd_we_i;
        r_wdata <= cmd_wdata_i;
        r_be    <= cmd_be_i;
        r_timer <= '0;
      end
      if (w_grant || w_abort) begin
        r_req <= 1'b0;
      end
      if (r_state == REQ || r_state == WAIT_R) begin
        r_timer <= w_timer;
      end
      if (w_capture) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_rdata   <= speriph_master.r_rdata;
        r_rsp_err     <= speriph_master.r_opc;
        r_rsp_timeout <= 1'b0;
      end
      if (w_abort) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_rdata   <= TIMEOUT_RDATA;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
      end
      // Advancing the tag here makes any late reply to this ID mismatch.
      if (w_release) begin
        r_rsp_valid <= 1'b0;
        r_id_q      <= r_id_q + PER_ID_WIDTH'(1);
        if (r_rsp_err && (r_err_cnt != 8'hFF)) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end
    end
  end

  // Gated by reset so the command port reads not-ready while reset is held.
  assign cmd_ready_o          = (r_state == IDLE) && rst_ni;
  assign rsp_valid_o          = r_rsp_valid;
  assign rsp_rdata_o          = r_rsp_rdata;
  assign rsp_err_o            = r_rsp_err;
  assign rsp_timeout_o        = r_rsp_timeout;
  assign err_cnt_o            = r_err_cnt;

  assign speriph_master.req   = r_req;
  assign speriph_master.add   = r_add;
  assign speriph_master.wen   = r_wen;
  assign speriph_master.wdata = r_wdata;
  assign speriph_master.be    = r_be;
  assign speriph_master.id    = r_id_q;

endmodule
`default_nettype wire

// File: tb/tb_cluster_periph_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_cluster_periph_initiator
// Brief    : Self-checking bench for cluster_periph_initiator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cluster_periph_initiator;

  localparam int          IDW      = 5;
  localparam int          TMO      = 8;
  localparam logic [31:0] TMO_DATA = 32'hBADACCE5;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [7:0]  err_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [IDW-1:0] exp_id = '0;
  logic [7:0]     exp_err_cnt = '0;

  always #5 clk = ~clk;

  XBAR_PERIPH_BUS #(.ID_WIDTH(IDW)) bus ();

  cluster_periph_initiator #(
    .PER_ID_WIDTH  (IDW),
    .TIMEOUT_CYCLES(TMO),
    .TIMEOUT_RDATA (TMO_DATA)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_addr_i    (cmd_addr),
    .cmd_we_i      (cmd_we),
    .cmd_wdata_i   (cmd_wdata),
    .cmd_be_i      (cmd_be),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .rsp_timeout_o (rsp_timeout),
    .err_cnt_o     (err_cnt),
    .speriph_master(bus.Master)
  );

  // One transaction: slave grants in REQ cycle gdly+1 and answers in WAIT_R
  // cycle rdly+1. Expected outcome comes from the timer rules: timer k in the
  // k-th cycle after acceptance, abort when it hits TMO before grant/reply.
  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int gdly, input int rdly,
                        input logic [31:0] rdata, input bit opc, input bit stale,
                        input logic [IDW-1:0] stale_id, input bit req_inject, input int hold);
    bit          exp_tmo;
    int          exp_req_cycles;
    int          exp_lat;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          cyc;
    int          req_cycles;
    int          wait_cnt;
    bit          in_req;
    bit          got;
    if (gdly + 1 > TMO) begin
      exp_tmo = 1; exp_req_cycles = TMO; exp_lat = TMO;
    end else begin
      exp_req_cycles = gdly + 1;
      if (gdly + 1 < TMO && gdly + rdly + 2 > TMO) begin
        exp_tmo = 1; exp_lat = TMO;
      end else begin
        exp_tmo = 0; exp_lat = gdly + rdly + 2;
      end
    end
    exp_rdata = exp_tmo ? TMO_DATA : rdata;
    exp_err   = exp_tmo | opc;

    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL cmd_ready_idle: got %b, expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_we = ~we; cmd_be = ~be;
    in_req = 1; cyc = 0; req_cycles = 0; wait_cnt = 0; got = 0;
    for (int t = 0; t < 64 && !got; t++) begin
      bus.gnt = 1'b0; bus.r_valid = 1'b0; bus.r_opc = 1'b0;
      if (rsp_valid === 1'b1) begin
        got = 1;
      end else begin
        cyc++;
        if (in_req) begin
          n_vec++;
          if (bus.req !== 1'b1 || bus.add !== addr || bus.wen !== ~we || bus.wdata !== wdata ||
              bus.be !== be || bus.id !== exp_id) begin
            n_err++;
            $display("FAIL req_fields cyc %0d: req=%b add=%h wen=%b wdata=%h be=%h id=%0d, expected req=1 add=%h wen=%b wdata=%h be=%h id=%0d",
                     cyc, bus.req, bus.add, bus.wen, bus.wdata, bus.be, bus.id,
                     addr, ~we, wdata, be, exp_id);
          end
          req_cycles++;
          if (req_inject && cyc == 1 && gdly >= 1) begin
            bus.r_valid = 1'b1; bus.r_id = exp_id; bus.r_rdata = ~rdata; bus.r_opc = ~opc;
          end
          if (cyc == gdly + 1) begin
            bus.gnt = 1'b1; in_req = 0;
          end
        end else begin
          wait_cnt++;
          n_vec++;
          if (bus.req !== 1'b0) begin
            n_err++; $display("FAIL req_low_wait: req=%b, expected 0", bus.req);
          end
          if (stale && wait_cnt == 1 && rdly >= 1) begin
            bus.r_valid = 1'b1; bus.r_id = stale_id; bus.r_rdata = ~rdata; bus.r_opc = 1'b1;
          end
          if (wait_cnt == rdly + 1) begin
            bus.r_valid = 1'b1; bus.r_id = exp_id; bus.r_rdata = rdata; bus.r_opc = opc;
          end
        end
        @(negedge clk);
      end
    end
    n_vec++;
    if (!got) begin
      n_err++; $display("FAIL rsp_wait_bound: rsp_valid never rose, expected after %0d cycles", exp_lat);
    end
    n_vec++;
    if (req_cycles != exp_req_cycles) begin
      n_err++; $display("FAIL req_cycles: got %0d, expected %0d", req_cycles, exp_req_cycles);
    end
    n_vec++;
    if (cyc != exp_lat) begin
      n_err++; $display("FAIL rsp_latency: got %0d, expected %0d", cyc, exp_lat);
    end
    for (int h = 0; h <= hold; h++) begin
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err ||
          rsp_timeout !== exp_tmo || cmd_ready !== 1'b0) begin
        n_err++;
        $display("FAIL rsp_fields: valid=%b rdata=%h err=%b tmo=%b ready=%b, expected valid=1 rdata=%h err=%b tmo=%b ready=0",
                 rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, exp_rdata, exp_err, exp_tmo);
      end
      rsp_ready = (h == hold);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    exp_id = exp_id + 1'b1;
    if (exp_err && exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
    n_vec++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || err_cnt !== exp_err_cnt) begin
      n_err++;
      $display("FAIL rsp_release: valid=%b ready=%b err_cnt=%0d, expected valid=0 ready=1 err_cnt=%0d",
               rsp_valid, cmd_ready, err_cnt, exp_err_cnt);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if (bus.req !== 1'b0 || bus.add !== '0 || bus.wen !== 1'b0 || bus.wdata !== '0 ||
        bus.be !== '0 || bus.id !== '0 || rsp_valid !== 1'b0 || rsp_rdata !== '0 ||
        rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || err_cnt !== '0 || cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s: req=%b add=%h wen=%b wdata=%h be=%h id=%0d rv=%b rd=%h err=%b tmo=%b cnt=%0d rdy=%b, expected all 0",
               tag, bus.req, bus.add, bus.wen, bus.wdata, bus.be, bus.id, rsp_valid,
               rsp_rdata, rsp_err, rsp_timeout, err_cnt, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_values");
    rst_ni = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_after_reset: got %b, expected 1", cmd_ready);
    end
    exp_id = '0; exp_err_cnt = '0;
  endtask

  task automatic test_read_immediate();
    do_txn(0, 32'h10200008, 32'h0, 4'hF, 0, 0, 32'h0000000F, 0, 0, '0, 0, 0);
    do_txn(0, 32'h1020000C, 32'h0, 4'hF, 0, 0, 32'h12345678, 0, 0, '0, 0, 0);
  endtask

  task automatic test_write_delayed();
    do_txn(1, 32'h10200040, 32'h1C008080, 4'hF, 5, 0, 32'hCAFE0001, 0, 0, '0, 1, 0);
  endtask

  task automatic test_stale_error();
    do_txn(0, 32'h10200010, 32'h0, 4'hF, 1, 2, 32'h0BAD0BAD, 1, 1, exp_id + 1'b1, 0, 1);
  endtask

  task automatic test_timeout();
    do_txn(0, 32'h10200020, 32'h0, 4'hF, 20, 0, 32'h55AA55AA, 0, 0, '0, 0, 0);
    do_txn(0, 32'h10200024, 32'h0, 4'hF, 0, 2, 32'h00C0FFEE, 0, 1, exp_id - 1'b1, 0, 0);
    do_txn(1, 32'h10200028, 32'h77, 4'h3, 3, 6, 32'h11112222, 0, 0, '0, 0, 0);
  endtask

  task automatic test_backpressure();
    do_txn(0, 32'h10200030, 32'h0, 4'hF, 2, 1, 32'hA5A5F00D, 1, 0, '0, 0, 10);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h10200050; cmd_wdata = 32'hDEADBEEF; cmd_be = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_vec++;
    if (bus.req !== 1'b1) begin
      n_err++; $display("FAIL mid_req_before_reset: got %b, expected 1", bus.req);
    end
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("reset_async_mid");
    @(negedge clk);
    rst_ni = 1'b1;
    exp_id = '0; exp_err_cnt = '0;
    bus.r_valid = 1'b1; bus.r_id = '0; bus.r_rdata = 32'h99999999; bus.r_opc = 1'b1;
    @(negedge clk);
    bus.r_valid = 1'b0; bus.r_opc = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL late_rsp_in_idle: valid=%b ready=%b, expected valid=0 ready=1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_id_wrap();
    for (int i = 0; i < 33; i++) begin
      do_txn(0, 32'h10200000 + 32'(i * 4), 32'h0, 4'hF, 0, 0, $urandom, 0, 0, '0, 0, 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int g;
      int r;
      g = $urandom_range(0, 9);
      r = (g == TMO - 1) ? 0 : $urandom_range(0, 4);
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), g, r,
             $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             exp_id ^ IDW'($urandom_range(1, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 260; i++) begin
      do_txn(0, 32'h10200100, 32'h0, 4'hF, 0, 0, $urandom, 1, 0, '0, 0, 0);
    end
  endtask

  initial begin
    bus.gnt = 1'b0; bus.r_valid = 1'b0; bus.r_opc = 1'b0; bus.r_id = '0; bus.r_rdata = '0;
    test_reset();
    test_read_immediate();
    test_write_delayed();
    test_stale_error();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_id_wrap();
    test_random();
    test_err_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
